// File: rtl/matrix_loader.sv
// Serial-to-FIFO matrix loader: takes N*N elements over valid/ready and pushes them to the FIFO with row/col tags.
// Optional sticky protocol-error flag: define LOADER_ERR_CHECK_EN to add the err output.
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int N_W    = 4,
  parameter int MAX_N  = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    N,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              full,
  output logic              push,
  output logic [DATA_W-1:0] wdata,
  output logic [N_W-1:0]    row,
  output logic [N_W-1:0]    col,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
`ifdef LOADER_ERR_CHECK_EN
  output logic              err,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: an element transfers on a rising edge where data_valid && data_ready;
  // data_ready is only high in LOAD with the FIFO not full, so push can never overflow it.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N_W-1:0] MAX_N_C = N_W'(MAX_N);

  state_t             state_q, state_d;
  logic [N_W-1:0]     n_q;
  logic [CNT_W-1:0]   count_q;
  logic [N_W-1:0]     row_q, col_q;
  logic [N_W-1:0]     n_clamped;
  logic [CNT_W-1:0]   total;
  logic               last_elem;
  logic               col_last;
  logic               accept;
  logic               start_ok;

  assign n_clamped = (N > MAX_N_C) ? MAX_N_C : N;
  assign total     = CNT_W'(n_q) * CNT_W'(n_q);
  assign last_elem = (count_q == total - CNT_W'(1));
  assign col_last  = (col_q == n_q - N_W'(1));
  assign start_ok  = (state_q == S_IDLE) && start;

  always_comb begin
    state_d    = state_q;
    data_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (n_clamped == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        data_ready = ~full;
        accept     = data_valid & ~full;
        if (accept && last_elem) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push      = accept;
  assign wdata     = accept ? data_in : '0;
  assign row       = row_q;
  assign col       = col_q;
  assign count     = count_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      count_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        n_q     <= n_clamped;
        count_q <= '0;
        row_q   <= '0;
        col_q   <= '0;
      end else if (accept) begin
        count_q <= count_q + CNT_W'(1);
        // Row-major walk: wrap the column at the end of each row.
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + N_W'(1);
        end else begin
          col_q <= col_q + N_W'(1);
        end
      end
    end
  end

`ifdef LOADER_ERR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((start_ok && (N == '0 || N > MAX_N_C)) ||
                 ((state_q == S_IDLE || state_q == S_DONE) && data_valid)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: the driver queues the expected push/done stream,
// an independent negedge monitor pops and compares whatever the DUT presents.
module tb_matrix_loader;
  localparam int DW = 8, NW = 4, CW = 7, MAXN = 8;
  localparam int EW = DW + 2 * NW + CW;

  logic          clk, rst, start, data_valid, data_ready, full, push, busy, done;
  logic [NW-1:0] N, row, col;
  logic [DW-1:0] data_in, wdata;
  logic [CW-1:0] count;
  logic [1:0]    state_dbg;
`ifdef LOADER_ERR_CHECK_EN
  logic          err;
`endif

  matrix_loader #(.DATA_W(DW), .N_W(NW), .MAX_N(MAXN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .full(full), .push(push),
    .wdata(wdata), .row(row), .col(col), .count(count), .busy(busy), .done(done),
`ifdef LOADER_ERR_CHECK_EN
    .err(err),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] done_q[$];
  logic [EW-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (push) begin
        chk("push_while_full", {31'd0, full}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("push_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wdata", {24'd0, wdata}, {24'd0, mon_e[EW-1 -: DW]});
          chk("row",   {28'd0, row},   {28'd0, mon_e[2*NW+CW-1 -: NW]});
          chk("col",   {28'd0, col},   {28'd0, mon_e[NW+CW-1 -: NW]});
          chk("count_at_push", {25'd0, count}, {25'd0, mon_e[CW-1:0]});
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          chk("final_count", {25'd0, count}, {25'd0, done_q.pop_front()});
          chk("done_busy_low", {31'd0, busy | data_ready}, 32'd0);
        end
      end
    end
  end

  // Driver
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; data_valid = 1'b0; full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_load(input int nn, input bit gaps, input bit rnd_full,
                          input int full_at, input int restart_at, input int reset_at);
    int n, total, idx, cyc, budget, full_left;
    bit pending, forced;
    logic [DW-1:0] d[$];
    n = (nn > MAXN) ? MAXN : nn;
    total = n * n;
    for (int i = 0; i < total; i++) begin
      if (!gaps && !rnd_full) d.push_back(DW'((i + 1) * 17));
      else d.push_back(DW'($urandom));
      exp_q.push_back({d[i], NW'(i / n), NW'(i % n), CW'(i)});
    end
    done_q.push_back(CW'(total));
    @(posedge clk); #1;
    start = 1'b1; N = NW'(nn);
    idx = 0; cyc = 0; pending = 1'b0; full_left = 3;
    budget = total * 20 + 50;
    while (idx < total && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start = (idx == restart_at);
      if (idx == restart_at) N = NW'(2);
      if (idx == reset_at) begin
        data_in = d[idx]; data_valid = 1'b1; full = 1'b0;
        #2 rst = 1'b0;
        exp_q.delete(); done_q.delete();
        #1;
        chk("rst_push",  {31'd0, push}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd0);
        chk("rst_count", {25'd0, count}, 32'd0);
        chk("rst_rowcol", {24'd0, row, col}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        @(negedge clk);
        chk("rst_no_done", {31'd0, done}, 32'd0);
        #1 data_valid = 1'b0; rst = 1'b1;
        return;
      end
      forced = (idx == full_at && full_left > 0);
      if (forced) begin
        full = 1'b1; full_left--;
      end else begin
        full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (!pending) begin
        pending = forced || !gaps || ($urandom_range(0, 2) != 0);
        data_in = pending ? d[idx] : DW'($urandom);
      end
      data_valid = pending;
      @(negedge clk);
      if (forced) begin
        chk("full_ready_low", {31'd0, data_ready}, 32'd0);
        chk("full_no_push",   {31'd0, push}, 32'd0);
        chk("full_count_hold", {25'd0, count}, full_at);
      end
      if (pending && data_ready) begin
        pending = 1'b0;
        idx++;
      end
    end
    if (idx < total) chk("load_timeout", idx, total);
    @(posedge clk); #1;
    start = 1'b0; data_valid = 1'b0; full = 1'b0; N = NW'($urandom);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("pushes_drained", exp_q.size(), 32'd0);
    chk("done_drained", done_q.size(), 32'd0);
    exp_q.delete(); done_q.delete();
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  // Test sequence
  initial begin
    rst = 1'b0; start = 1'b1; data_valid = 1'b1; full = 1'b0;
    N = NW'(3); data_in = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {30'd0, state_dbg}, 32'd0);
    chk("reset_outputs", {18'd0, push, busy, done, data_ready, count, row, col} == '0, 32'd1);
    chk("reset_wdata", {24'd0, wdata}, 32'd0);
`ifdef LOADER_ERR_CHECK_EN
    chk("reset_err", {31'd0, err}, 32'd0);
`endif
    start = 1'b0; data_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_ready", {31'd0, data_ready}, 32'd0);
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    run_load(2, 1'b0, 1'b0, -1, -1, -1);
    run_load(3, 1'b0, 1'b0, 2, -1, -1);
    run_load(4, 1'b0, 1'b0, -1, 5, -1);
    run_load(3, 1'b0, 1'b0, -1, -1, 4);
    run_load(1, 1'b0, 1'b0, -1, -1, -1);

    do_reset();
    run_load(0, 1'b1, 1'b0, -1, -1, -1);
`ifdef LOADER_ERR_CHECK_EN
    chk("err_n0", {31'd0, err}, 32'd1);
`endif
    do_reset();
    run_load(15, 1'b1, 1'b1, -1, -1, -1);
`ifdef LOADER_ERR_CHECK_EN
    chk("err_n15", {31'd0, err}, 32'd1);
`endif

    for (int k = 0; k < 12; k++) begin
      run_load(($urandom_range(0, 4) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 6),
               1'b1, 1'b1, -1, -1, -1);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
